// File: rtl/stencil_pkg.sv
// Shared fixed-point definitions for the stencil update pipe: default formats and
// saturation bounds, plus a scalar multiply-shift-saturate helper.
package stencil_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_FRAC_W = 27;

    localparam logic signed [DEF_DATA_W-1:0] ONE     =
        {{(DEF_DATA_W-DEF_FRAC_W-1){1'b0}}, 1'b1, {DEF_FRAC_W{1'b0}}};
    localparam logic signed [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam logic signed [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

    typedef struct packed {
        logic                         ovf;
        logic signed [DEF_DATA_W-1:0] val;
    } fx_res_t;

    // Full-width product, floor shift by the fraction width, clamp to DEF_DATA_W.
    function automatic fx_res_t fx_mul_sat(input logic signed [DEF_DATA_W-1:0] a,
                                           input logic signed [DEF_DATA_W-1:0] b);
        logic signed [2*DEF_DATA_W-1:0] p;
        logic        [DEF_DATA_W:0]     hi;
        fx_res_t                        r;
        p     = (2*DEF_DATA_W)'(a) * (2*DEF_DATA_W)'(b);
        p     = p >>> DEF_FRAC_W;
        hi    = p[2*DEF_DATA_W-1:DEF_DATA_W-1];
        r.ovf = !((&hi) || !(|hi));
        r.val = r.ovf ? (hi[DEF_DATA_W] ? SAT_MIN : SAT_MAX) : p[DEF_DATA_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/stencil_update_pipe_fx_mul_sat.sv
// Combinational signed fixed-point multiply: full product, arithmetic shift right
// by FRAC_W (floor), then clamp to OUT_W bits with an overflow indication.
module fx_mul_sat #(
    parameter int A_W    = 32,
    parameter int B_W    = 32,
    parameter int OUT_W  = 32,
    parameter int FRAC_W = 27
) (
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [OUT_W-1:0] p_o,
    output logic                    ovf_o
);

    localparam int P_W = A_W + B_W;
    localparam logic signed [OUT_W-1:0] O_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] O_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [P_W-1:0]     prod;
    logic signed [P_W-1:0]     shifted;
    logic        [P_W-OUT_W:0] hi;

    assign prod    = P_W'(a_i) * P_W'(b_i);
    assign shifted = prod >>> FRAC_W;

    // Result fits only when every bit above the kept sign bit repeats it.
    assign hi    = shifted[P_W-1:OUT_W-1];
    assign ovf_o = !((&hi) || !(|hi));
    assign p_o   = ovf_o ? (hi[P_W-OUT_W] ? O_MIN : O_MAX) : shifted[OUT_W-1:0];

endmodule

// File: rtl/stencil_update_pipe.sv
// Pipelined diffusion update new = c + k*(u+d+l+r-4c): three register stages, one sample/cycle;
// a stalled output freezes the whole pipe and drops in_ready, empty stages never block acceptance.
module stencil_update_pipe
    import stencil_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int TAG_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] coef_alpha,
    input  logic signed [DATA_W-1:0] coef_delta,
    input  logic                     coef_load,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_center,
    input  logic signed [DATA_W-1:0] in_up,
    input  logic signed [DATA_W-1:0] in_down,
    input  logic signed [DATA_W-1:0] in_left,
    input  logic signed [DATA_W-1:0] in_right,
    input  logic                     in_boundary,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_center,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     sat_flag,
    input  logic                     sat_clr
);

    localparam int LAP_W = DATA_W + 3;
    localparam int SUM_W = DATA_W + 4;
    localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic                     init_q;
    logic                     en;
    logic                     accept;
    logic signed [DATA_W-1:0] k_q;
    logic signed [DATA_W-1:0] k_d;
    logic                     k_ovf;

    logic                     s1_vld_q;
    logic signed [LAP_W-1:0]  lap_d;
    logic signed [LAP_W-1:0]  s1_lap_q;
    logic signed [DATA_W-1:0] s1_c_q;
    logic signed [DATA_W-1:0] s1_k_q;
    logic                     s1_bnd_q;
    logic [TAG_W-1:0]         s1_tag_q;

    logic signed [LAP_W-1:0]  prod_d;
    logic                     prod_ovf;
    logic                     s2_vld_q;
    logic signed [LAP_W-1:0]  s2_prod_q;
    logic signed [DATA_W-1:0] s2_c_q;
    logic                     s2_bnd_q;
    logic [TAG_W-1:0]         s2_tag_q;

    logic signed [SUM_W-1:0]  sum;
    logic [SUM_W-DATA_W:0]    sum_hi;
    logic                     sum_ovf;
    logic signed [DATA_W-1:0] res_d;

    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_center_q;
    logic [TAG_W-1:0]         out_tag_q;
    logic                     sat_q;
    logic                     sat_d;

    // Only the output stage can stall; in_ready waits one clock out of reset.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en && init_q;
    assign accept   = in_valid && in_ready;

    fx_mul_sat #(
        .A_W    (DATA_W),
        .B_W    (DATA_W),
        .OUT_W  (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_k_mul (
        .a_i   (coef_alpha),
        .b_i   (coef_delta),
        .p_o   (k_d),
        .ovf_o (k_ovf)
    );

    assign lap_d = (LAP_W'(in_up)    - LAP_W'(in_center))
                 + (LAP_W'(in_down)  - LAP_W'(in_center))
                 + (LAP_W'(in_left)  - LAP_W'(in_center))
                 + (LAP_W'(in_right) - LAP_W'(in_center));

    fx_mul_sat #(
        .A_W    (LAP_W),
        .B_W    (DATA_W),
        .OUT_W  (LAP_W),
        .FRAC_W (FRAC_W)
    ) u_s2_mul (
        .a_i   (s1_lap_q),
        .b_i   (s1_k_q),
        .p_o   (prod_d),
        .ovf_o (prod_ovf)
    );

    assign sum     = SUM_W'(s2_c_q) + SUM_W'(s2_prod_q);
    assign sum_hi  = sum[SUM_W-1:DATA_W-1];
    assign sum_ovf = !((&sum_hi) || !(|sum_hi));

    always_comb begin
        res_d = sum[DATA_W-1:0];
        if (s2_bnd_q) begin
            res_d = s2_c_q;
        end else if (sum_ovf) begin
            res_d = sum_hi[SUM_W-DATA_W] ? D_MIN : D_MAX;
        end
    end

    // Boundary cells discard the arithmetic, so their overflow is not reported.
    always_comb begin
        sat_d = sat_q;
        if (sat_clr) begin
            sat_d = 1'b0;
        end
        if ((coef_load && k_ovf) ||
            (en && s1_vld_q && !s1_bnd_q && prod_ovf) ||
            (en && s2_vld_q && !s2_bnd_q && sum_ovf)) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_q       <= 1'b0;
            k_q          <= '0;
            sat_q        <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_lap_q     <= '0;
            s1_c_q       <= '0;
            s1_k_q       <= '0;
            s1_bnd_q     <= 1'b0;
            s1_tag_q     <= '0;
            s2_vld_q     <= 1'b0;
            s2_prod_q    <= '0;
            s2_c_q       <= '0;
            s2_bnd_q     <= 1'b0;
            s2_tag_q     <= '0;
            out_valid_q  <= 1'b0;
            out_center_q <= '0;
            out_tag_q    <= '0;
        end else begin
            init_q <= 1'b1;
            sat_q  <= sat_d;
            if (coef_load) begin
                k_q <= k_d;
            end
            if (en) begin
                s1_vld_q    <= accept;
                s2_vld_q    <= s1_vld_q;
                out_valid_q <= s2_vld_q;
                if (accept) begin
                    s1_lap_q <= lap_d;
                    s1_c_q   <= in_center;
                    s1_k_q   <= k_q;
                    s1_bnd_q <= in_boundary;
                    s1_tag_q <= in_tag;
                end
                if (s1_vld_q) begin
                    s2_prod_q <= prod_d;
                    s2_c_q    <= s1_c_q;
                    s2_bnd_q  <= s1_bnd_q;
                    s2_tag_q  <= s1_tag_q;
                end
                if (s2_vld_q) begin
                    out_center_q <= res_d;
                    out_tag_q    <= s2_tag_q;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_center = out_center_q;
    assign out_tag    = out_tag_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_stencil_update_pipe.sv
// Directed bench for stencil_update_pipe: hand-computed 5.27 vectors covering latency,
// boundary hold, saturation, backpressure, coefficient snapshot and mid-flight reset.
module tb_stencil_update_pipe;

    localparam logic [31:0] ONE_FX = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] coef_alpha = '0;
    logic [31:0] coef_delta = '0;
    logic        coef_load = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_center = '0;
    logic [31:0] in_up = '0;
    logic [31:0] in_down = '0;
    logic [31:0] in_left = '0;
    logic [31:0] in_right = '0;
    logic        in_boundary = 1'b0;
    logic [15:0] in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_center;
    logic [15:0] out_tag;
    logic        sat_flag;
    logic        sat_clr = 1'b0;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    stencil_update_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .coef_alpha  (coef_alpha),
        .coef_delta  (coef_delta),
        .coef_load   (coef_load),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_center   (in_center),
        .in_up       (in_up),
        .in_down     (in_down),
        .in_left     (in_left),
        .in_right    (in_right),
        .in_boundary (in_boundary),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_center  (out_center),
        .out_tag     (out_tag),
        .sat_flag    (sat_flag),
        .sat_clr     (sat_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] c, input logic [31:0] u, input logic [31:0] d,
                         input logic [31:0] l, input logic [31:0] r, input logic bnd,
                         input logic [15:0] tag);
        in_center   = c;
        in_up       = u;
        in_down     = d;
        in_left     = l;
        in_right    = r;
        in_boundary = bnd;
        in_tag      = tag;
        in_valid    = 1'b1;
    endtask

    // Present one sample, wait (bounded) for the accept edge, then withdraw it.
    task automatic send(input logic [31:0] c, input logic [31:0] u, input logic [31:0] d,
                        input logic [31:0] l, input logic [31:0] r, input logic bnd,
                        input logic [15:0] tag);
        drive(c, u, d, l, r, bnd, tag);
        #1;
        for (int i = 0; i < 20 && !in_ready; i++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out();
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    endtask

    task automatic load_k(input logic [31:0] a, input logic [31:0] d);
        coef_alpha = a;
        coef_delta = d;
        coef_load  = 1'b1;
        @(posedge clk);
        #1 coef_load = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sent;
        int          got;
        int          stall_cyc;
        logic        acc;
        logic        fire;
        logic [31:0] held;

        // Reset state
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_out_center", 64'(out_center), 64'(32'h0));
        check("rst_out_tag", 64'(out_tag), 64'(16'h0));
        check("rst_sat_flag", 64'(sat_flag), 64'(1'b0));
        check("rst_in_ready", 64'(in_ready), 64'(1'b0));
        check("rst_k", 64'(dut.k_q), 64'(32'h0));
        @(negedge clk);
        reset = 1'b0;
        #1 check("rdy_before_clock", 64'(in_ready), 64'(1'b0));
        @(posedge clk);
        #1 check("rdy_after_clock", 64'(in_ready), 64'(1'b1));
        @(negedge clk);

        // Basic update with exact latency: k = 0.25, lap = 4.0 -> 1.0
        load_k(32'h0200_0000, 32'h0800_0000);
        check("k_basic", 64'(dut.k_q), 64'(32'h0200_0000));
        send(32'h0, ONE_FX, ONE_FX, ONE_FX, ONE_FX, 1'b0, 16'h0011);
        check("lat_edge1_valid", 64'(out_valid), 64'(1'b0));
        @(posedge clk);
        #1 check("lat_edge2_valid", 64'(out_valid), 64'(1'b0));
        @(posedge clk);
        #1;
        check("lat_edge3_valid", 64'(out_valid), 64'(1'b1));
        check("basic_center", 64'(out_center), 64'(32'h0800_0000));
        check("basic_tag", 64'(out_tag), 64'(16'h0011));
        check("basic_sat", 64'(sat_flag), 64'(1'b0));
        @(negedge clk);

        // Boundary hold
        send(32'h0123_4567, ONE_FX, ONE_FX, ONE_FX, ONE_FX, 1'b1, 16'hBEEF);
        wait_out();
        check("bnd_center", 64'(out_center), 64'(32'h0123_4567));
        check("bnd_tag", 64'(out_tag), 64'(16'hBEEF));
        check("bnd_sat", 64'(sat_flag), 64'(1'b0));
        @(negedge clk);

        // Positive saturation at the final add: 15.0 + 3.5
        load_k(32'h0800_0000, 32'h0800_0000);
        send(32'h7800_0000, 32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000,
             1'b0, 16'h0003);
        wait_out();
        check("satp_center", 64'(out_center), 64'(32'h7FFF_FFFF));
        check("satp_flag", 64'(sat_flag), 64'(1'b1));
        @(negedge clk);
        pulse_clr();
        check("satp_clr", 64'(sat_flag), 64'(1'b0));
        @(negedge clk);

        // Negative saturation with sat_clr held high: set must win
        sat_clr = 1'b1;
        send(32'h8800_0000, 32'h8100_0000, 32'h8100_0000, 32'h8100_0000, 32'h8100_0000,
             1'b0, 16'h0004);
        wait_out();
        check("satn_center", 64'(out_center), 64'(32'h8000_0000));
        check("satn_set_wins", 64'(sat_flag), 64'(1'b1));
        @(posedge clk);
        #1 check("satn_clr", 64'(sat_flag), 64'(1'b0));
        sat_clr = 1'b0;
        @(negedge clk);

        // Coefficient overflow: ~16 * ~16
        load_k(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        check("ksat_k", 64'(dut.k_q), 64'(32'h7FFF_FFFF));
        check("ksat_flag", 64'(sat_flag), 64'(1'b1));
        @(negedge clk);
        pulse_clr();
        check("ksat_clr", 64'(sat_flag), 64'(1'b0));
        @(negedge clk);

        // Floor shift: lap = -3 LSB, k = 0.25 -> prod = -1 LSB, result 0
        load_k(32'h0200_0000, 32'h0800_0000);
        send(32'h0000_0001, 32'h0, 32'h0, 32'h0, 32'h0000_0001, 1'b0, 16'h0005);
        wait_out();
        check("floor_center", 64'(out_center), 64'(32'h0));
        @(negedge clk);

        // Negative neighbours: 0.25 * -4.0 = -1.0
        send(32'h0, 32'hF800_0000, 32'hF800_0000, 32'hF800_0000, 32'hF800_0000,
             1'b0, 16'h0006);
        wait_out();
        check("neg_center", 64'(out_center), 64'(32'hF800_0000));
        check("neg_tag", 64'(out_tag), 64'(16'h0006));
        @(negedge clk);

        // Coefficient change on the accept cycle of A: A keeps 0.25, B gets 0.5
        drive(32'h0, ONE_FX, ONE_FX, ONE_FX, ONE_FX, 1'b0, 16'h000A);
        coef_alpha = 32'h0400_0000;
        coef_delta = 32'h0800_0000;
        coef_load  = 1'b1;
        @(posedge clk);
        #1;
        coef_load = 1'b0;
        drive(32'h0, ONE_FX, ONE_FX, ONE_FX, ONE_FX, 1'b0, 16'h000B);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("kchg_k", 64'(dut.k_q), 64'(32'h0400_0000));
        wait_out();
        check("kchg_a_center", 64'(out_center), 64'(32'h0800_0000));
        check("kchg_a_tag", 64'(out_tag), 64'(16'h000A));
        @(negedge clk);
        check("kchg_b_valid", 64'(out_valid), 64'(1'b1));
        check("kchg_b_center", 64'(out_center), 64'(32'h1000_0000));
        check("kchg_b_tag", 64'(out_tag), 64'(16'h000B));
        @(negedge clk);

        // Backpressure: six samples, output stalled for five cycles mid-stream
        load_k(32'h0200_0000, 32'h0800_0000);
        sent      = 0;
        got       = 0;
        stall_cyc = 0;
        held      = '0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            if (sent < 6) begin
                drive(32'h0, 32'(sent + 1) * ONE_FX, 32'(sent + 1) * ONE_FX,
                      32'(sent + 1) * ONE_FX, 32'(sent + 1) * ONE_FX, 1'b0, 16'(sent + 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                if (stall_cyc == 0) held = out_center;
                else check("bp_hold_center", 64'(out_center), 64'(held));
                check("bp_in_ready", 64'(in_ready), 64'(1'b0));
                stall_cyc++;
            end
            if (out_valid && out_ready) begin
                check("bp_tag", 64'(out_tag), 64'(16'(got + 1)));
                check("bp_center", 64'(out_center), 64'(32'(got + 1) * ONE_FX));
            end
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            @(posedge clk);
            if (acc) sent++;
            if (fire) got++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_stall_cycles", 64'(stall_cyc), 64'(5));
        check("bp_count", 64'(got), 64'(6));
        check("bp_drained", 64'(out_valid), 64'(1'b0));

        // Reset with three samples in flight
        for (int i = 0; i < 3; i++) begin
            drive(32'h0, ONE_FX, ONE_FX, ONE_FX, ONE_FX, 1'b0, 16'(32'h21 + i));
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("rstm_pre_valid", 64'(out_valid), 64'(1'b1));
        check("rstm_pre_tag", 64'(out_tag), 64'(16'h0021));
        #2 reset = 1'b1;
        #1;
        check("rstm_out_valid", 64'(out_valid), 64'(1'b0));
        check("rstm_out_center", 64'(out_center), 64'(32'h0));
        check("rstm_out_tag", 64'(out_tag), 64'(16'h0));
        check("rstm_in_ready", 64'(in_ready), 64'(1'b0));
        check("rstm_k", 64'(dut.k_q), 64'(32'h0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rstm_rdy", 64'(in_ready), 64'(1'b1));
        check("rstm_no_stale", 64'(out_valid), 64'(1'b0));
        @(negedge clk);
        send(32'h0123_4567, ONE_FX, ONE_FX, ONE_FX, ONE_FX, 1'b0, 16'h0055);
        wait_out();
        check("rstm_k0_center", 64'(out_center), 64'(32'h0123_4567));
        check("rstm_k0_tag", 64'(out_tag), 64'(16'h0055));
        @(negedge clk);
        check("rstm_single", 64'(out_valid), 64'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
